// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// bcd_pkg : shared BCD digit types and helpers for the cascade counter
// Rev 1.0 : initial release
// ============================================================================
package bcd_pkg;

  localparam int         BCD_W          = 4;
  localparam logic [3:0] BCD_NINE       = 4'd9;
  localparam int         BCD_MAX_DIGITS = 8;

  typedef logic [BCD_W-1:0]                bcd_digit_t;
  typedef logic [BCD_W*BCD_MAX_DIGITS-1:0] bcd_word_t;

  function automatic logic bcd_valid(input bcd_digit_t nibble);
    return nibble <= BCD_NINE;
  endfunction

  function automatic logic bcd_all_valid(input bcd_word_t v, input int n);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (i < n && !bcd_valid(v[i*BCD_W +: BCD_W])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // The first differing digit from the MSD down decides; equal values pass.
  function automatic logic bcd_le(input bcd_word_t a, input bcd_word_t b, input int n);
    logic decided;
    logic le;
    decided = 1'b0;
    le      = 1'b1;
    for (int i = BCD_MAX_DIGITS-1; i >= 0; i--) begin
      if (!decided && i < n) begin
        if (a[i*BCD_W +: BCD_W] < b[i*BCD_W +: BCD_W]) begin
          le      = 1'b1;
          decided = 1'b1;
        end else if (a[i*BCD_W +: BCD_W] > b[i*BCD_W +: BCD_W]) begin
          le      = 1'b0;
          decided = 1'b1;
        end
      end
    end
    return le;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
// bcd_digit : one BCD digit register with gated inc/dec and load
// Rev 1.0 : initial release
// ============================================================================
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  input  logic       dec,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       is9,
  output logic       is0
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  always_comb begin
    digit_d = digit_q;
    if (ld) begin
      digit_d = ld_val;
    end else if (inc && carry_in) begin
      digit_d = (digit_q == BCD_NINE) ? 4'd0 : digit_q + 4'd1;
    end else if (dec && borrow_in) begin
      digit_d = (digit_q == 4'd0) ? BCD_NINE : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q   = digit_q;
  assign is9 = (digit_q == BCD_NINE);
  assign is0 = (digit_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bcd_cascade_counter.sv
`default_nettype none
// ============================================================================
// bcd_cascade_counter : multi-digit up/down BCD counter, programmable terminal
// Rev 1.0 : initial release
// ============================================================================
module bcd_cascade_counter
  import bcd_pkg::*;
#(
  parameter int                  DIGITS    = 4,
  parameter logic [4*DIGITS-1:0] MAX_VALUE = 16'h9675
) (
  input  logic                  clk,
  input  logic                  rstbutton,
  input  logic                  ena0in,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [4*DIGITS-1:0]   q,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  tc,
  output logic                  load_err
);

  localparam int CNT_W = BCD_W * DIGITS;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  wrap_val;
  logic [CNT_W-1:0]  ld_val;
  logic [DIGITS-1:0] is9;
  logic [DIGITS-1:0] is0;
  logic [DIGITS:0]   carry;
  logic [DIGITS:0]   borrow;
  bcd_word_t         load_word;
  bcd_word_t         max_word;
  logic              clr;
  logic              ce;
  logic              at_max;
  logic              at_zero;
  logic              wrap;
  logic              load_ok;
  logic              digit_ld;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              tc_q;
  logic              tc_d;
  logic              load_err_q;
  logic              load_err_d;

  always_comb begin
    load_word             = '0;
    load_word[CNT_W-1:0]  = load_data;
    max_word              = '0;
    max_word[CNT_W-1:0]   = MAX_VALUE;
    load_ok = bcd_all_valid(load_word, DIGITS) && bcd_le(load_word, max_word, DIGITS);

    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      carry[i+1]  = carry[i]  & is9[i];
      borrow[i+1] = borrow[i] & is0[i];
    end

    clr     = !rstbutton;
    ce      = !ena0in && !load;
    at_zero = borrow[DIGITS];
    // An all-nines count must wrap too, never roll over silently through the chain.
    at_max  = (count == MAX_VALUE) || carry[DIGITS];
    wrap    = ce && (dir ? at_zero : at_max);

    wrap_val = dir ? MAX_VALUE : '0;
    ld_val   = load ? load_data : wrap_val;
    digit_ld = (load && load_ok) || wrap;
    cnt_inc  = ce && !dir && !wrap;
    cnt_dec  = ce &&  dir && !wrap;

    digit_en = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (rstbutton && ce) begin
        if (wrap) begin
          digit_en[i] = (count[i*BCD_W +: BCD_W] != wrap_val[i*BCD_W +: BCD_W]);
        end else begin
          digit_en[i] = dir ? borrow[i] : carry[i];
        end
      end
    end

    tc_d       = wrap;
    load_err_d = load && !load_ok;
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .clr       (clr),
      .ld        (digit_ld),
      .ld_val    (ld_val[gi*BCD_W +: BCD_W]),
      .inc       (cnt_inc),
      .dec       (cnt_dec),
      .carry_in  (carry[gi]),
      .borrow_in (borrow[gi]),
      .q         (count[gi*BCD_W +: BCD_W]),
      .is9       (is9[gi]),
      .is0       (is0[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!rstbutton) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = count;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_cascade_counter.sv
`default_nettype none
// ============================================================================
// tb_bcd_cascade_counter : directed bench with a decimal reference model,
// covering a 4-digit/9675 and a 2-digit/59 instance side by side
// ============================================================================
module tb_bcd_cascade_counter;

  logic        clk = 1'b0;
  logic        rstbutton;
  logic        ena0in;
  logic        dir;
  logic        load;
  logic [15:0] load_data;
  logic [7:0]  load_data2;
  logic [15:0] q4;
  logic [3:0]  en4;
  logic        tc4;
  logic        err4;
  logic [7:0]  q2;
  logic [1:0]  en2;
  logic        tc2;
  logic        err2;

  always #5 clk = ~clk;

  bcd_cascade_counter #(.DIGITS(4), .MAX_VALUE(16'h9675)) dut4 (
    .clk(clk), .rstbutton(rstbutton), .ena0in(ena0in), .dir(dir), .load(load),
    .load_data(load_data), .q(q4), .digit_en(en4), .tc(tc4), .load_err(err4)
  );

  bcd_cascade_counter #(.DIGITS(2), .MAX_VALUE(8'h59)) dut2 (
    .clk(clk), .rstbutton(rstbutton), .ena0in(ena0in), .dir(dir), .load(load),
    .load_data(load_data2), .q(q2), .digit_en(en2), .tc(tc2), .load_err(err2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain decimal arithmetic) ----------------
  int MAXI [2] = '{9675, 59};
  int ND   [2] = '{4, 2};
  int mv   [2];
  bit mtc  [2];
  bit merr [2];
  bit chk_on = 1'b0;

  function automatic int to_int(input logic [31:0] v, input int n);
    int r = 0;
    for (int i = n - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int x, input int n);
    logic [31:0] r = '0;
    int y = x;
    for (int i = 0; i < n; i++) begin
      r[i*4 +: 4] = 4'(y % 10);
      y = y / 10;
    end
    return r;
  endfunction

  function automatic bit all_ok(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ldata(input int u);
    return (u == 0) ? {16'b0, load_data} : {24'b0, load_data2};
  endfunction

  function automatic int next_val(input int u, input int v);
    if (dir) return (v == 0) ? MAXI[u] : v - 1;
    return (v == MAXI[u]) ? 0 : v + 1;
  endfunction

  function automatic logic [31:0] exp_en(input int u);
    logic [31:0] e = '0;
    logic [31:0] a;
    logic [31:0] b;
    if (rstbutton && !load && !ena0in) begin
      a = to_bcd(mv[u], ND[u]);
      b = to_bcd(next_val(u, mv[u]), ND[u]);
      for (int i = 0; i < ND[u]; i++) e[i] = (a[i*4 +: 4] != b[i*4 +: 4]);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rstbutton) begin
        mv[u] = 0; mtc[u] = 1'b0; merr[u] = 1'b0;
      end else if (load) begin
        mtc[u] = 1'b0;
        if (all_ok(ldata(u), ND[u]) && to_int(ldata(u), ND[u]) <= MAXI[u]) begin
          mv[u] = to_int(ldata(u), ND[u]); merr[u] = 1'b0;
        end else begin
          merr[u] = 1'b1;
        end
      end else if (!ena0in) begin
        merr[u] = 1'b0;
        mtc[u]  = dir ? (mv[u] == 0) : (mv[u] == MAXI[u]);
        mv[u]   = next_val(u, mv[u]);
      end else begin
        mtc[u] = 1'b0; merr[u] = 1'b0;
      end
    end
    if (!rstbutton) chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model q4",        {16'b0, q4},   to_bcd(mv[0], 4));
      check("model tc4",       {31'b0, tc4},  {31'b0, mtc[0]});
      check("model load_err4", {31'b0, err4}, {31'b0, merr[0]});
      check("model digit_en4", {28'b0, en4},  exp_en(0));
      check("model q2",        {24'b0, q2},   to_bcd(mv[1], 2));
      check("model tc2",       {31'b0, tc2},  {31'b0, mtc[1]});
      check("model load_err2", {31'b0, err2}, {31'b0, merr[1]});
      check("model digit_en2", {30'b0, en2},  exp_en(1));
    end
  end

  // ---------------- directed stimulus with literal expectations ---------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] d4, input logic [7:0] d2);
    load = 1'b1; load_data = d4; load_data2 = d2;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    bit found;
    rstbutton = 1'b0; ena0in = 1'b1; dir = 1'b0; load = 1'b0;
    load_data = '0; load_data2 = '0;
    step(2);
    check("reset q",        {16'b0, q4},   32'h0);
    check("reset tc",       {31'b0, tc4},  32'h0);
    check("reset load_err", {31'b0, err4}, 32'h0);

    rstbutton = 1'b1; ena0in = 1'b0;
    step(1);  check("first count q", {16'b0, q4}, 32'h0001);
    step(8);  check("q at 0009", {16'b0, q4}, 32'h0009);
              check("digit_en at 0009", {28'b0, en4}, 32'h3);
              check("digit_en2 at 09", {30'b0, en2}, 32'h3);
    step(1);  check("q at 0010", {16'b0, q4}, 32'h0010);
    step(89); check("digit_en at 0099", {28'b0, en4}, 32'h7);
    step(1);  check("q at 0100", {16'b0, q4}, 32'h0100);

    do_load(16'h9674, 8'h58);
    check("load 9674", {16'b0, q4}, 32'h9674);
    step(1); check("q 9675", {16'b0, q4}, 32'h9675); check("tc before wrap", {31'b0, tc4}, 32'h0);
    step(1); check("up wrap q", {16'b0, q4}, 32'h0000); check("up wrap tc", {31'b0, tc4}, 32'h1);
    dir = 1'b1;
    step(1); check("down wrap q", {16'b0, q4}, 32'h9675); check("down wrap tc", {31'b0, tc4}, 32'h1);
    step(1); check("q 9674 down", {16'b0, q4}, 32'h9674); check("tc after wrap", {31'b0, tc4}, 32'h0);
    do_load(16'h1000, 8'h10);
    check("load 1000", {16'b0, q4}, 32'h1000);
    step(1); check("down to 0999", {16'b0, q4}, 32'h0999);

    ena0in = 1'b1;
    do_load(16'h9676, 8'h60);
    check("reject 9676 q", {16'b0, q4}, 32'h0999); check("reject 9676 err", {31'b0, err4}, 32'h1);
    check("reject 60 err2", {31'b0, err2}, 32'h1);
    step(1); check("err one cycle", {31'b0, err4}, 32'h0);
    do_load(16'h12A4, 8'h5A);
    check("reject 12A4 q", {16'b0, q4}, 32'h0999); check("reject 12A4 err", {31'b0, err4}, 32'h1);
    step(1);

    dir = 1'b0; ena0in = 1'b0;
    load = 1'b1; load_data = 16'h0500; load_data2 = 8'h05;
    #1 check("digit_en during load", {28'b0, en4}, 32'h0);
    step(1); load = 1'b0; ena0in = 1'b1;
    check("load 0500 no inc", {16'b0, q4}, 32'h0500);

    do_load(16'h4321, 8'h43);
    for (int k = 0; k < 5; k++) begin
      check("hold q", {16'b0, q4}, 32'h4321);
      check("hold digit_en", {28'b0, en4}, 32'h0);
      check("hold tc", {31'b0, tc4}, 32'h0);
      step(1);
    end

    do_load(16'h9675, 8'h59);
    check("at 9675", {16'b0, q4}, 32'h9675);
    rstbutton = 1'b0; load = 1'b1; load_data = 16'h9676; ena0in = 1'b0;
    #1 check("digit_en in reset", {28'b0, en4}, 32'h0);
    step(1);
    check("reset over load q", {16'b0, q4}, 32'h0); check("reset over load err", {31'b0, err4}, 32'h0);
    rstbutton = 1'b1; ena0in = 1'b1;
    do_load(16'h9675, 8'h59);
    rstbutton = 1'b0; ena0in = 1'b0;
    step(1);
    check("reset over wrap q", {16'b0, q4}, 32'h0); check("reset over wrap tc", {31'b0, tc4}, 32'h0);

    rstbutton = 1'b1;
    step(59); check("dut2 at 59", {24'b0, q2}, 32'h59);
    step(1);  check("dut2 wrap 00", {24'b0, q2}, 32'h0); check("dut2 wrap tc", {31'b0, tc2}, 32'h1);

    found = 1'b0;
    for (int c = 0; c < 20000 && !found; c++) begin
      step(1);
      if (tc4) found = 1'b1;
    end
    check("first tc seen", {31'b0, found}, 32'h1);
    cnt = 0; found = 1'b0;
    while (!found && cnt < 20000) begin
      step(1); cnt++;
      if (tc4) found = 1'b1;
    end
    check("up period", cnt, 32'd9676);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_cascade_counter.md
# bcd_cascade_counter

Parametrised multi-digit BCD counter with a programmable terminal value, successor to the fixed four-digit 0000–9675 count controller. It holds all digit registers internally and generates the per-digit carry/borrow chain. It adds up/down counting, synchronous preset load with range checking, and a registered wrap pulse. It sits between the debounced front-panel inputs and the seven-segment display driver.

## Interface
- `DIGITS`, 4, number of BCD digits (1–8)
- `MAX_VALUE`, 16'h9675, packed BCD terminal value, width `4*DIGITS`, every nibble ≤ 9
- `clk`  input  1  system clock, all state on rising edge
- `rstbutton`  input  1  reset, synchronous, active-low
- `ena0in`  input  1  count pause, active-high: 0 = count, 1 = hold
- `dir`  input  1  0 = up, 1 = down
- `load`  input  1  single-cycle preset request
- `load_data`  input  `4*DIGITS`  packed BCD preset value
- `q`  output  `4*DIGITS`  packed BCD count, digit 0 in bits [3:0]
- `digit_en`  output  `DIGITS`  combinational; bit i = digit i changes on the next edge
- `tc`  output  1  registered wrap pulse
- `load_err`  output  1  registered rejected-load pulse

## Operation
- Priority, highest first: reset, load, count, hold.
- Reset (`rstbutton`=0 at the edge): `q`=0, `tc`=0, `load_err`=0. The reset overrides load and count in the same cycle.
- Load: `load_data` is accepted when every nibble is ≤ 9 and the packed value is ≤ `MAX_VALUE`. Comparison is digit-wise from the MSD down.
  - On accept: `q` ← `load_data` and `load_err`=0.
  - On reject: `q` is unchanged and `load_err`=1 for one cycle.
  - A load suppresses counting in that cycle, whatever the value of `ena0in`.
- Count enable: `ce = !ena0in && !load`.
- Up (`dir`=0), `q` ≠ `MAX_VALUE`:
  - Digit 0 increments.
  - Digit i>0 increments when all lower digits are 9.
  - A digit at 9 that increments becomes 0.
- Up, `q` == `MAX_VALUE`: `q` ← 0 and `tc`=1.
- Down (`dir`=1), `q` ≠ 0:
  - Digit 0 decrements.
  - Digit i>0 decrements when all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
- Down, `q` == 0: `q` ← `MAX_VALUE` and `tc`=1.
- `digit_en[i]`:
  - Equals `ce` AND (carry or borrow into digit i), OR `ce` AND wrap.
  - On wrap, it is set for every digit whose value differs between the old and new `q`.
  - It is 0 during reset and load.
- `dir` may change on any cycle. It takes effect at the next edge and needs no settling.
- Hold: `q` is unchanged and `tc`=0.

## Timing
- `q` updates on the edge where `ce` (or `load`) is sampled, so count latency is one cycle.
- `tc` is high during exactly the cycle in which `q` shows the wrapped value (0 after an up-wrap, `MAX_VALUE` after a down-wrap). It is low on every other cycle.
- `load_err` is high during the cycle after the rejected load edge, for one cycle only.
- `digit_en` is valid in the same cycle as its inputs. It is purely combinational from `q`, `dir`, `ena0in`, `load` and `rstbutton`.
- Continuous up-count period is `MAX_VALUE`+1 cycles in decimal: 9676 cycles for the default.
- Reset deasserting in a cycle with `ena0in`=0 produces the first increment on the following edge, so `q`=1 one cycle after the first non-reset edge.

## Structure
- Shared package `bcd_pkg` contains:
  - `BCD_W` = 4 and `BCD_NINE` = 4'd9
  - a `bcd_digit_t` typedef
  - a function `bcd_valid(nibble)`
  - a function `bcd_le(a, b, n)` for the packed compare
- Sub-module `bcd_digit`: one digit register with inc/dec, carry-in, borrow-in, synchronous clear and load. It produces the `is9`/`is0` flags. `bcd_cascade_counter` instantiates it `DIGITS` times through a generate loop. Wrap and terminal detection live in the top level.

## Test plan
- Reset, then up-count with `ena0in`=0 from 0 → `q` reaches 0009, 0010 the next cycle, then 0099 → 0100. `digit_en` = 4'b0011 and then 4'b0111 on those transitions.
- Load 9674, count up → `q` shows 9675 and then 0000. `tc`=1 only during the 0000 cycle, and the full up-count period from 0 is 9676 cycles.
- `dir`=1 from 0000 → `q`=9675 with `tc`=1. Continuing gives 9674, then a load of 1000 followed by a down-count gives 0999.
- Load 9676 → `q` holds and `load_err`=1 for one cycle. Load 12A4 (nibble A, i.e. 10, is invalid) → same result. Load 0500 together with `ena0in`=0 → `q`=0500 and no increment in that cycle.
- `ena0in`=1 for 5 cycles mid-count at 4321 → `q` stays 4321, `digit_en`=0 and `tc`=0.
- `rstbutton`=0 asserted at `q`=9675 with `load`=1 → `q`=0000, `tc`=0 and `load_err`=0 at the next edge. Repeat with `DIGITS`=2 and `MAX_VALUE`=8'h59: the count wraps 59 → 00.
